gpu_fill_engine: RTL and testbench
==================================

Name: gpu_fill_engine

Overview:
- Rectangle-fill responder for the GPU command controller's fill dispatch interface.
- Accepts a fill request (run_fill_i plus two corner coordinates) and emits one frame-buffer pixel write per covered pixel, in raster order, over a valid/ready port.
- Returns a single-cycle finished_fill_o pulse, which causes the controller to pop the command FIFO.
- Sits between the command controller and the frame-buffer write arbiter.

Parameters:
SCREEN_W, 640, horizontal resolution in pixels
SCREEN_H, 480, vertical resolution in pixels
WIDTH_BITS, 10, x coordinate width
HEIGHT_BITS, 9, y coordinate width
CHANNEL_BITS, 8, bits per colour channel
ADDR_BITS, 19, frame-buffer pixel address width

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
run_fill_i  in  1  fill request, level, held by controller until finished
x1_i  in  WIDTH_BITS  corner A x
y1_i  in  HEIGHT_BITS  corner A y
x2_i  in  WIDTH_BITS  corner B x
y2_i  in  HEIGHT_BITS  corner B y
r_i / g_i / b_i  in  CHANNEL_BITS each  fill colour
pixel_ready_i  in  1  frame buffer accepts current write
pixel_valid_o  out  1  write request valid
pixel_addr_o  out  ADDR_BITS  linear address = y*SCREEN_W + x
pixel_rgb_o  out  3*CHANNEL_BITS  colour, {r,g,b}
finished_fill_o  out  1  one-cycle completion pulse
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; internal coordinate and colour registers 0.
- Reset asserted mid-operation aborts the fill immediately; no further writes are issued.
- Four-state FSM: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - When run_fill_i=1, latch xmin=min(x1,x2), xmax=max(x1,x2), ymin=min(y1,y2), ymax=max(y1,y2) and the colour; go to SETUP.
  - Inputs are not sampled again until the next IDLE.
- SETUP (1 cycle): row_base=ymin*SCREEN_W, x=xmin, y=ymin; go to DRAW.
- DRAW:
  - pixel_valid_o=1, pixel_addr_o=row_base+x (truncated to ADDR_BITS), pixel_rgb_o=latched colour.
  - No change while pixel_ready_i=0. Address and colour stay stable until accepted; no pixel is skipped or duplicated.
  - On acceptance with x<xmax: x++.
  - On acceptance with x==xmax and y<ymax: x=xmin, y++, row_base+=SCREEN_W.
  - On acceptance with x==xmax and y==ymax: go to DONE.
- DONE (1 cycle): finished_fill_o=1, pixel_valid_o=0; go to IDLE.
- Timing:
  - First pixel_valid_o is 2 cycles after the cycle run_fill_i is first seen high in IDLE.
  - With ready held high, N pixels take N cycles in DRAW, and finished_fill_o occurs on cycle N+2 after run is sampled.
  - Throughput is 1 pixel/cycle.
- Controller handoff:
  - The controller drops run_fill_i the cycle after finished_fill_o, so no restart occurs on the same command.
  - run_fill_i dropping while busy is ignored; the fill is committed.
- Degenerate rectangle: x1==x2 and y1==y2 gives exactly 1 pixel.
- Full-width rows and single rows/columns need no special case.
- Arithmetic: row_base is computed from ymin in SETUP, then advanced only by addition. The multiply may be a constant-coefficient shift/add.

Optional Feature:
GPU_FILL_CLIP_EN
- Defined: in IDLE, each latched coordinate is clamped after sorting. x values >= SCREEN_W become SCREEN_W-1; y values >= SCREEN_H become SCREEN_H-1. Writes therefore never leave the visible frame.
- Undefined: coordinates are used unmodified; addresses outside the frame wrap modulo 2^ADDR_BITS. The controller is responsible for range checking.

Test Plan:
- 1x1 at (5,3), ready=1 -> single write, addr 1925; finished_fill_o pulses 3 cycles after run sampled; busy_o low afterwards.
- (2,1)-(4,2), ready=1 -> addrs 642,643,644,1282,1283,1284 on consecutive cycles; finished one cycle after 1284.
- Swapped corners (4,2)-(2,1) -> identical sequence to the previous test.
- Same rectangle, pixel_ready_i low for 3 cycles while addr 643 is presented -> 643 held stable, then 644; total 6 writes, no duplicates.
- GPU_FILL_CLIP_EN defined, (638,478)-(700,500) -> addrs 306558,306559,307198,307199, then finished.
- n_rst pulsed during DRAW of a 10x10 fill -> all outputs 0 next edge. A new 1x1 fill at (0,0) then completes normally with addr 0.

Source files
------------

// File: rtl/gpu_fill_engine_if.sv
// gpu_fill_engine_if
//   Fill dispatch and pixel write bundle for gpu_fill_engine.
//   Request side:  run_fill_i, corner coordinates x1/y1/x2/y2, colour r/g/b.
//   Status side:   finished_fill_o (one-cycle pulse), busy_o.
//   Pixel side:    pixel_valid_o / pixel_ready_i handshake, pixel_addr_o, pixel_rgb_o.
//   Modports:
//     slave  - the fill engine (consumes requests, produces pixel writes)
//     master - the environment (command controller plus frame-buffer arbiter)
interface gpu_fill_engine_if #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int ADDR_BITS    = 19
);
  logic                      run_fill_i;
  logic [WIDTH_BITS-1:0]     x1_i;
  logic [HEIGHT_BITS-1:0]    y1_i;
  logic [WIDTH_BITS-1:0]     x2_i;
  logic [HEIGHT_BITS-1:0]    y2_i;
  logic [CHANNEL_BITS-1:0]   r_i;
  logic [CHANNEL_BITS-1:0]   g_i;
  logic [CHANNEL_BITS-1:0]   b_i;
  logic                      pixel_ready_i;
  logic                      pixel_valid_o;
  logic [ADDR_BITS-1:0]      pixel_addr_o;
  logic [3*CHANNEL_BITS-1:0] pixel_rgb_o;
  logic                      finished_fill_o;
  logic                      busy_o;

  modport slave (
    input  run_fill_i, x1_i, y1_i, x2_i, y2_i, r_i, g_i, b_i, pixel_ready_i,
    output pixel_valid_o, pixel_addr_o, pixel_rgb_o, finished_fill_o, busy_o
  );

  modport master (
    output run_fill_i, x1_i, y1_i, x2_i, y2_i, r_i, g_i, b_i, pixel_ready_i,
    input  pixel_valid_o, pixel_addr_o, pixel_rgb_o, finished_fill_o, busy_o
  );
endinterface

// File: rtl/gpu_fill_engine.sv
// gpu_fill_engine
//   Rectangle fill responder. Takes a fill request (two corners + colour),
//   emits one frame-buffer write per covered pixel in raster order over a
//   valid/ready port, then pulses finished_fill_o for one cycle.
//   Ports:
//     clk    - system clock
//     n_rst  - asynchronous active-low reset (aborts any fill in progress)
//     bus    - gpu_fill_engine_if.slave: request, status and pixel write port
//   Optional build macro:
//     GPU_FILL_CLIP_EN - clamp sorted corners to the visible frame
//                        (x <= SCREEN_W-1, y <= SCREEN_H-1). Without it the
//                        coordinates are used as given and addresses wrap
//                        modulo 2^ADDR_BITS.
module gpu_fill_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int ADDR_BITS    = 19
) (
  input  logic               clk,
  input  logic               n_rst,
  gpu_fill_engine_if.slave   bus
);

  localparam logic [ADDR_BITS-1:0] ROW_STRIDE = ADDR_BITS'(SCREEN_W);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  typedef struct packed {
    logic [WIDTH_BITS-1:0]     xmin;
    logic [WIDTH_BITS-1:0]     xmax;
    logic [HEIGHT_BITS-1:0]    ymin;
    logic [HEIGHT_BITS-1:0]    ymax;
    logic [3*CHANNEL_BITS-1:0] rgb;
  } rect_t;

  state_t                 state;
  rect_t                  rect;
  rect_t                  req;
  logic [WIDTH_BITS-1:0]  x;
  logic [HEIGHT_BITS-1:0] y;
  logic [ADDR_BITS-1:0]   row_base;
  logic [ADDR_BITS-1:0]   row_base_init;
  logic [ADDR_BITS-1:0]   addr;
  logic                   valid;
  logic                   finished;
  logic                   busy;

  // Sort the corners (and optionally clamp) so the draw loop only ever
  // walks upward from min to max.
  always_comb begin
    req      = '0;
    req.xmin = (bus.x1_i < bus.x2_i) ? bus.x1_i : bus.x2_i;
    req.xmax = (bus.x1_i < bus.x2_i) ? bus.x2_i : bus.x1_i;
    req.ymin = (bus.y1_i < bus.y2_i) ? bus.y1_i : bus.y2_i;
    req.ymax = (bus.y1_i < bus.y2_i) ? bus.y2_i : bus.y1_i;
    req.rgb  = {bus.r_i, bus.g_i, bus.b_i};
`ifdef GPU_FILL_CLIP_EN
    if ({1'b0, req.xmin} >= (WIDTH_BITS+1)'(SCREEN_W))  req.xmin = WIDTH_BITS'(SCREEN_W-1);
    if ({1'b0, req.xmax} >= (WIDTH_BITS+1)'(SCREEN_W))  req.xmax = WIDTH_BITS'(SCREEN_W-1);
    if ({1'b0, req.ymin} >= (HEIGHT_BITS+1)'(SCREEN_H)) req.ymin = HEIGHT_BITS'(SCREEN_H-1);
    if ({1'b0, req.ymax} >= (HEIGHT_BITS+1)'(SCREEN_H)) req.ymax = HEIGHT_BITS'(SCREEN_H-1);
`endif
  end

  // Only multiply in SETUP; constant coefficient, so this reduces to shift/add.
  assign row_base_init = ADDR_BITS'(rect.ymin) * ROW_STRIDE;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      rect     <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      addr     <= '0;
      valid    <= 1'b0;
      finished <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.run_fill_i) begin
            rect  <= req;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          row_base <= row_base_init;
          x        <= rect.xmin;
          y        <= rect.ymin;
          addr     <= row_base_init + ADDR_BITS'(rect.xmin);
          valid    <= 1'b1;
          state    <= DRAW;
        end
        DRAW: begin
          // Address/colour are held until the arbiter takes the write.
          if (bus.pixel_ready_i) begin
            if (x < rect.xmax) begin
              x    <= x + 1'b1;
              addr <= addr + 1'b1;
            end else if (y < rect.ymax) begin
              x        <= rect.xmin;
              y        <= y + 1'b1;
              row_base <= row_base + ROW_STRIDE;
              addr     <= row_base + ROW_STRIDE + ADDR_BITS'(rect.xmin);
            end else begin
              valid    <= 1'b0;
              finished <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          // run_fill_i is still high here; it is not looked at until IDLE.
          finished <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          valid    <= 1'b0;
          finished <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.pixel_valid_o   = valid;
  assign bus.pixel_addr_o    = addr;
  assign bus.pixel_rgb_o     = rect.rgb;
  assign bus.finished_fill_o = finished;
  assign bus.busy_o          = busy;

endmodule

// File: tb/tb_gpu_fill_engine.sv
// tb_gpu_fill_engine
//   Directed bench for gpu_fill_engine. Stimulus pushes hand-computed pixel
//   writes into a scoreboard queue; an independent monitor pops and compares
//   on every accepted write and checks that stalled writes hold steady.
module tb_gpu_fill_engine;
  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  gpu_fill_engine_if bus ();

  gpu_fill_engine dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    int          addr;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_en  = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int addr, input logic [23:0] rgb);
    exp_t e;
    e.addr = addr;
    e.rgb  = rgb;
    sb_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  bit       hold = 1'b0;
  int       hold_addr = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!sb_en || !n_rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_hold_addr", int'(bus.pixel_addr_o), hold_addr);
        chk("stall_hold_valid", int'(bus.pixel_valid_o), 1);
      end
      hold = 1'b0;
      if (bus.pixel_valid_o) begin
        if (!bus.pixel_ready_i) begin
          hold      = 1'b1;
          hold_addr = int'(bus.pixel_addr_o);
        end else if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d, expected no write", bus.pixel_addr_o);
        end else begin
          e = sb_q.pop_front();
          chk("pixel_addr", int'(bus.pixel_addr_o), e.addr);
          chk("pixel_rgb", int'(bus.pixel_rgb_o), int'(e.rgb));
        end
      end
    end
  end

  // Issue one fill and wait (bounded) for finished_fill_o. Cycle 0 is the
  // cycle run_fill_i is first high; ready is low for cycles
  // [stall_at, stall_at+stall_len).
  task automatic run_fill(input int x1, input int y1, input int x2, input int y2,
                          input logic [23:0] rgb, input int stall_at, input int stall_len,
                          input int exp_fin, input string tag);
    int cyc  = 0;
    bit seen = 1'b0;
    @(posedge clk); #1;
    bus.x1_i = 10'(x1); bus.y1_i = 9'(y1);
    bus.x2_i = 10'(x2); bus.y2_i = 9'(y2);
    bus.r_i  = rgb[23:16]; bus.g_i = rgb[15:8]; bus.b_i = rgb[7:0];
    bus.pixel_ready_i = 1'b1;
    bus.run_fill_i    = 1'b1;
    while (cyc < 200) begin
      @(negedge clk);
      if (bus.finished_fill_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      bus.pixel_ready_i = !(cyc >= stall_at && cyc < stall_at + stall_len);
    end
    chk({tag, "_finish_cycle"}, seen ? cyc : -1, exp_fin);
    @(posedge clk); #1;
    bus.run_fill_i    = 1'b0;
    bus.pixel_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_after"}, int'(bus.busy_o), 0);
    chk({tag, "_finished_after"}, int'(bus.finished_fill_o), 0);
    chk({tag, "_all_written"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    int saw_valid;
    bus.run_fill_i = 1'b0;
    bus.x1_i = '0; bus.y1_i = '0; bus.x2_i = '0; bus.y2_i = '0;
    bus.r_i = '0; bus.g_i = '0; bus.b_i = '0;
    bus.pixel_ready_i = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_valid", int'(bus.pixel_valid_o), 0);
    chk("reset_finished", int'(bus.finished_fill_o), 0);
    chk("reset_busy", int'(bus.busy_o), 0);
    chk("reset_addr", int'(bus.pixel_addr_o), 0);
    chk("reset_rgb", int'(bus.pixel_rgb_o), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // 1x1 at (5,3): 3*640+5
    push_exp(1925, 24'h123456);
    run_fill(5, 3, 5, 3, 24'h123456, 0, 0, 3, "single");

    // (2,1)-(4,2)
    push_exp(642, 24'hA0B0C0); push_exp(643, 24'hA0B0C0); push_exp(644, 24'hA0B0C0);
    push_exp(1282, 24'hA0B0C0); push_exp(1283, 24'hA0B0C0); push_exp(1284, 24'hA0B0C0);
    run_fill(2, 1, 4, 2, 24'hA0B0C0, 0, 0, 8, "rect");

    // swapped corners
    push_exp(642, 24'h0F1E2D); push_exp(643, 24'h0F1E2D); push_exp(644, 24'h0F1E2D);
    push_exp(1282, 24'h0F1E2D); push_exp(1283, 24'h0F1E2D); push_exp(1284, 24'h0F1E2D);
    run_fill(4, 2, 2, 1, 24'h0F1E2D, 0, 0, 8, "swapped");

    // ready low for 3 cycles while 643 is presented (cycles 3..5)
    push_exp(642, 24'h55AA33); push_exp(643, 24'h55AA33); push_exp(644, 24'h55AA33);
    push_exp(1282, 24'h55AA33); push_exp(1283, 24'h55AA33); push_exp(1284, 24'h55AA33);
    run_fill(2, 1, 4, 2, 24'h55AA33, 3, 3, 11, "stall");

`ifdef GPU_FILL_CLIP_EN
    push_exp(306558, 24'hFFFFFF); push_exp(306559, 24'hFFFFFF);
    push_exp(307198, 24'hFFFFFF); push_exp(307199, 24'hFFFFFF);
    run_fill(638, 478, 700, 500, 24'hFFFFFF, 0, 0, 6, "clip");
`else
    // x=640 is past the right edge and simply continues linearly
    push_exp(306558, 24'hFFFFFF); push_exp(306559, 24'hFFFFFF); push_exp(306560, 24'hFFFFFF);
    run_fill(638, 478, 640, 478, 24'hFFFFFF, 0, 0, 5, "noclip");
`endif

    // reset in the middle of a 10x10 fill
    sb_en = 1'b0;
    @(posedge clk); #1;
    bus.x1_i = 10'd0; bus.y1_i = 9'd0; bus.x2_i = 10'd9; bus.y2_i = 9'd9;
    bus.r_i = 8'h11; bus.g_i = 8'h22; bus.b_i = 8'h33;
    bus.pixel_ready_i = 1'b1;
    bus.run_fill_i    = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("abort_valid", int'(bus.pixel_valid_o), 0);
    chk("abort_finished", int'(bus.finished_fill_o), 0);
    chk("abort_busy", int'(bus.busy_o), 0);
    chk("abort_addr", int'(bus.pixel_addr_o), 0);
    chk("abort_rgb", int'(bus.pixel_rgb_o), 0);
    bus.run_fill_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    saw_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.pixel_valid_o || bus.busy_o) saw_valid++;
    end
    chk("no_activity_after_abort", saw_valid, 0);
    sb_en = 1'b1;

    push_exp(0, 24'h010203);
    run_fill(0, 0, 0, 0, 24'h010203, 0, 0, 3, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish before 200000");
    $fatal(1);
  end
endmodule
